// File: rtl/ccip_c0tx_almfull_buffer.sv
// CCI-P channel-0 read-request buffer. It holds requests an AFU issues after
// almost-full and replays them to the mux leaf port while its almost-full is clear.
package ccip_c0tx_pkg;
  localparam int C0_HDR_W = 74;

  typedef struct packed {
    logic                valid;
    logic [C0_HDR_W-1:0] hdr;
  } t_if_ccip_c0_Tx;
endpackage

module ccip_c0tx_almfull_buffer
  import ccip_c0tx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SLACK = 8
) (
  input  logic                     pClk,
  input  logic                     SoftReset_n,
  input  t_if_ccip_c0_Tx           afu_c0Tx,
  output logic                     afu_c0TxAlmFull,
  output t_if_ccip_c0_Tx           mux_c0Tx,
  input  logic                     mux_c0TxAlmFull,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [31:0]              sent_cnt,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [C0_HDR_W-1:0] mem [DEPTH];
  logic [PW-1:0]       wrPtr;
  logic [PW-1:0]       rdPtr;
  logic [CW-1:0]       count;
  logic [CW-1:0]       countNext;
  logic                full;
  logic                pop;
  logic                pushAcc;
  logic                drop;

  // Full/empty come from the count; a push into a full FIFO is still taken
  // when the head leaves in the same cycle.
  always_comb begin
    full      = (count == CW'(DEPTH));
    pop       = (count != '0) && !mux_c0TxAlmFull;
    pushAcc   = afu_c0Tx.valid && (!full || pop);
    drop      = afu_c0Tx.valid && !pushAcc;
    countNext = count + CW'(pushAcc) - CW'(pop);
  end

  always_ff @(posedge pClk) begin
    if (pushAcc) begin
      mem[wrPtr] <= afu_c0Tx.hdr;
    end
  end

  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      wrPtr           <= '0;
      rdPtr           <= '0;
      count           <= '0;
      afu_c0TxAlmFull <= 1'b0;
      overflow        <= 1'b0;
      sent_cnt        <= '0;
      mux_c0Tx        <= '0;
    end else begin
      count           <= countNext;
      afu_c0TxAlmFull <= (countNext >= CW'(DEPTH - SLACK));
      mux_c0Tx.valid  <= pop;
      if (pushAcc) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr        <= rdPtr + PW'(1);
        mux_c0Tx.hdr <= mem[rdPtr];
        sent_cnt     <= sent_cnt + 32'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign occupancy = count;

endmodule

// File: tb/tb_ccip_c0tx_almfull_buffer.sv
// Directed self-checking bench for ccip_c0tx_almfull_buffer.
module tb_ccip_c0tx_almfull_buffer;
  import ccip_c0tx_pkg::*;

  localparam int DEPTH = 16;
  localparam int SLACK = 8;

  logic           pClk = 1'b0;
  logic           softReset_n;
  t_if_ccip_c0_Tx afuTx;
  t_if_ccip_c0_Tx muxTx;
  logic           afuAlmFull;
  logic           muxAlmFull;
  logic [4:0]     occupancy;
  logic [31:0]    sentCnt;
  logic           overflow;

  int vecs = 0;
  int errs = 0;
  logic [C0_HDR_W-1:0] expQ [$];

  ccip_c0tx_almfull_buffer #(.DEPTH(DEPTH), .SLACK(SLACK)) dut (
    .pClk            (pClk),
    .SoftReset_n     (softReset_n),
    .afu_c0Tx        (afuTx),
    .afu_c0TxAlmFull (afuAlmFull),
    .mux_c0Tx        (muxTx),
    .mux_c0TxAlmFull (muxAlmFull),
    .occupancy       (occupancy),
    .sent_cnt        (sentCnt),
    .overflow        (overflow)
  );

  always #5 pClk = ~pClk;

  function automatic logic [C0_HDR_W-1:0] mkHdr(input int i);
    logic [31:0] idx;
    idx = 32'(i);
    return {10'h2A5, idx * 32'h9E37_79B9, idx};
  endfunction

  task automatic doReset();
    softReset_n = 1'b0;
    afuTx       = '0;
    muxAlmFull  = 1'b0;
    expQ.delete();
    repeat (2) @(negedge pClk);
    softReset_n = 1'b1;
  endtask

  task automatic test_reset();
    softReset_n = 1'b0;
    afuTx       = '0;
    muxAlmFull  = 1'b0;
    #3;
    vecs++;
    if (muxTx !== '0) begin
      errs++; $display("[TB] FAIL reset_mux: got %h expected 0", muxTx);
    end
    vecs++;
    if ({afuAlmFull, overflow, occupancy, sentCnt} !== '0) begin
      errs++; $display("[TB] FAIL reset_status: got almFull=%b ovf=%b occ=%0d sent=%0d expected all 0",
                       afuAlmFull, overflow, occupancy, sentCnt);
    end
    @(negedge pClk);
    softReset_n = 1'b1;
  endtask

  task automatic test_single();
    logic [C0_HDR_W-1:0] h;
    h = {10'h155, 64'hCAFE_F00D_1234_00A5};
    afuTx.valid = 1'b1;
    afuTx.hdr   = h;
    @(negedge pClk);
    afuTx.valid = 1'b0;
    vecs++;
    if (muxTx.valid !== 1'b0 || occupancy !== 5'd1) begin
      errs++; $display("[TB] FAIL single_early: got valid=%b occ=%0d expected valid=0 occ=1", muxTx.valid, occupancy);
    end
    @(negedge pClk);
    vecs++;
    if (muxTx.valid !== 1'b1 || muxTx.hdr !== h) begin
      errs++; $display("[TB] FAIL single_issue: got valid=%b hdr=%h expected valid=1 hdr=%h", muxTx.valid, muxTx.hdr, h);
    end
    vecs++;
    if (sentCnt !== 32'd1 || occupancy !== 5'd0) begin
      errs++; $display("[TB] FAIL single_count: got sent=%0d occ=%0d expected sent=1 occ=0", sentCnt, occupancy);
    end
    @(negedge pClk);
    vecs++;
    if (muxTx.valid !== 1'b0 || muxTx.hdr !== h) begin
      errs++; $display("[TB] FAIL single_pulse: got valid=%b hdr=%h expected valid=0 hdr=%h", muxTx.valid, muxTx.hdr, h);
    end
  endtask

  task automatic test_backpressure();
    doReset();
    muxAlmFull = 1'b1;
    for (int i = 0; i < 16; i++) begin
      afuTx.valid = 1'b1;
      afuTx.hdr   = mkHdr(100 + i);
      @(negedge pClk);
      if (i == 6) begin
        vecs++;
        if (afuAlmFull !== 1'b0) begin
          errs++; $display("[TB] FAIL almfull_7: got %b expected 0", afuAlmFull);
        end
      end
      if (i == 7) begin
        vecs++;
        if (afuAlmFull !== 1'b1) begin
          errs++; $display("[TB] FAIL almfull_8: got %b expected 1", afuAlmFull);
        end
      end
    end
    vecs++;
    if (occupancy !== 5'd16 || overflow !== 1'b0) begin
      errs++; $display("[TB] FAIL fill16: got occ=%0d ovf=%b expected occ=16 ovf=0", occupancy, overflow);
    end
    afuTx.hdr = mkHdr(999);
    @(negedge pClk);
    afuTx.valid = 1'b0;
    vecs++;
    if (overflow !== 1'b1 || occupancy !== 5'd16) begin
      errs++; $display("[TB] FAIL overflow_set: got ovf=%b occ=%0d expected ovf=1 occ=16", overflow, occupancy);
    end
    @(negedge pClk);
    vecs++;
    if (overflow !== 1'b1) begin
      errs++; $display("[TB] FAIL overflow_sticky: got %b expected 1", overflow);
    end
    muxAlmFull = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge pClk);
      vecs++;
      if (muxTx.valid !== 1'b1 || muxTx.hdr !== mkHdr(100 + i)) begin
        errs++; $display("[TB] FAIL drain_%0d: got valid=%b hdr=%h expected valid=1 hdr=%h",
                         i, muxTx.valid, muxTx.hdr, mkHdr(100 + i));
      end
    end
    @(negedge pClk);
    vecs++;
    if (muxTx.valid !== 1'b0 || occupancy !== 5'd0 || afuAlmFull !== 1'b0 || sentCnt !== 32'd16 || overflow !== 1'b1) begin
      errs++; $display("[TB] FAIL drain_end: got valid=%b occ=%0d almFull=%b sent=%0d ovf=%b expected 0,0,0,16,1",
                       muxTx.valid, occupancy, afuAlmFull, sentCnt, overflow);
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    muxAlmFull = 1'b1;
    for (int i = 0; i < 16; i++) begin
      afuTx.valid = 1'b1;
      afuTx.hdr   = mkHdr(200 + i);
      expQ.push_back(mkHdr(200 + i));
      @(negedge pClk);
    end
    muxAlmFull = 1'b0;
    afuTx.hdr  = mkHdr(300);
    expQ.push_back(mkHdr(300));
    for (int k = 1; k <= 36; k++) begin
      logic [C0_HDR_W-1:0] e;
      @(negedge pClk);
      e = expQ.pop_front();
      vecs++;
      if (muxTx.valid !== 1'b1 || muxTx.hdr !== e) begin
        errs++; $display("[TB] FAIL b2b_%0d: got valid=%b hdr=%h expected valid=1 hdr=%h", k, muxTx.valid, muxTx.hdr, e);
      end
      if (k <= 20) begin
        vecs++;
        if (occupancy !== 5'd16 || overflow !== 1'b0) begin
          errs++; $display("[TB] FAIL b2b_full_%0d: got occ=%0d ovf=%b expected occ=16 ovf=0", k, occupancy, overflow);
        end
      end
      if (k < 20) begin
        afuTx.hdr = mkHdr(300 + k);
        expQ.push_back(mkHdr(300 + k));
      end else begin
        afuTx.valid = 1'b0;
      end
    end
    @(negedge pClk);
    vecs++;
    if (muxTx.valid !== 1'b0 || sentCnt !== 32'd36 || overflow !== 1'b0 || occupancy !== 5'd0) begin
      errs++; $display("[TB] FAIL b2b_end: got valid=%b sent=%0d ovf=%b occ=%0d expected 0,36,0,0",
                       muxTx.valid, sentCnt, overflow, occupancy);
    end
  endtask

  task automatic test_wrap();
    int pi;
    int got;
    int cyc;
    doReset();
    afuTx.valid = 1'b1;
    afuTx.hdr   = mkHdr(500);
    expQ.push_back(mkHdr(500));
    pi  = 1;
    got = 0;
    cyc = 0;
    while (cyc < 200 && got < 40) begin
      @(negedge pClk);
      cyc++;
      if (muxTx.valid === 1'b1) begin
        vecs++;
        if (expQ.size() == 0) begin
          errs++; $display("[TB] FAIL wrap_spurious: got hdr=%h expected no valid", muxTx.hdr);
        end else begin
          logic [C0_HDR_W-1:0] e;
          e = expQ.pop_front();
          if (muxTx.hdr !== e) begin
            errs++; $display("[TB] FAIL wrap_order_%0d: got %h expected %h", got, muxTx.hdr, e);
          end
        end
        got++;
      end
      if (pi < 40) begin
        afuTx.hdr = mkHdr(500 + pi);
        expQ.push_back(mkHdr(500 + pi));
        pi++;
      end else begin
        afuTx.valid = 1'b0;
      end
      muxAlmFull = (cyc % 3 == 0) && ($urandom_range(0, 1) == 1);
    end
    muxAlmFull = 1'b0;
    vecs++;
    if (got != 40) begin
      errs++; $display("[TB] FAIL wrap_timeout: got %0d pulses expected 40", got);
    end
    vecs++;
    if (sentCnt !== 32'd40 || overflow !== 1'b0) begin
      errs++; $display("[TB] FAIL wrap_sent: got sent=%0d ovf=%b expected sent=40 ovf=0", sentCnt, overflow);
    end
  endtask

  task automatic test_counter_wrap();
    logic [31:0] expSent;
    @(negedge pClk);
    force dut.sent_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.sent_cnt;
    expSent = 32'hFFFF_FFFE;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        afuTx.valid = 1'b1;
        afuTx.hdr   = mkHdr(700 + c);
      end else begin
        afuTx.valid = 1'b0;
      end
      @(negedge pClk);
      if (muxTx.valid === 1'b1) expSent = expSent + 32'd1;
      vecs++;
      if (sentCnt !== expSent) begin
        errs++; $display("[TB] FAIL cnt_wrap_%0d: got %h expected %h", c, sentCnt, expSent);
      end
    end
    vecs++;
    if (sentCnt !== 32'd1) begin
      errs++; $display("[TB] FAIL cnt_wrap_end: got %h expected 00000001", sentCnt);
    end
  endtask

  task automatic test_mid_reset();
    doReset();
    muxAlmFull = 1'b1;
    for (int i = 0; i < 6; i++) begin
      afuTx.valid = 1'b1;
      afuTx.hdr   = mkHdr(800 + i);
      @(negedge pClk);
    end
    afuTx.valid = 1'b0;
    muxAlmFull  = 1'b0;
    @(negedge pClk);
    vecs++;
    if (muxTx.valid !== 1'b1 || occupancy !== 5'd5) begin
      errs++; $display("[TB] FAIL mid_pre: got valid=%b occ=%0d expected valid=1 occ=5", muxTx.valid, occupancy);
    end
    #2;
    softReset_n = 1'b0;
    #1;
    vecs++;
    if (muxTx !== '0 || {afuAlmFull, overflow, occupancy, sentCnt} !== '0) begin
      errs++; $display("[TB] FAIL mid_reset: got mux=%h almFull=%b ovf=%b occ=%0d sent=%0d expected all 0",
                       muxTx, afuAlmFull, overflow, occupancy, sentCnt);
    end
    repeat (2) @(negedge pClk);
    softReset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge pClk);
      vecs++;
      if (muxTx.valid !== 1'b0 || occupancy !== 5'd0) begin
        errs++; $display("[TB] FAIL post_reset_%0d: got valid=%b occ=%0d expected valid=0 occ=0", c, muxTx.valid, occupancy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_counter_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
